// File: rtl/evm_pkg.sv
// Shared definitions for the voting machine: default sizes, FSM states and the
// saturation ceiling that both the tally block and the downstream divider assume.
package evm_pkg;

  localparam int EVM_WIDTH    = 7;
  localparam int EVM_NUM_CAND = 4;

  localparam logic [EVM_WIDTH-1:0] TALLY_MAX = {EVM_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMED    = 2'd1,
    ST_WAIT_REL = 2'd2,
    ST_CLOSED   = 2'd3
  } evm_state_t;

endpackage

// File: rtl/vote_counter.sv
// Unsigned tally counter with synchronous clear (priority) and increment enable.
module vote_counter
  import evm_pkg::*;
#(
  parameter int WIDTH = EVM_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/vote_tally.sv
// Ballot FSM and per-candidate tallies; presents count/total as divider
// operands once the poll is closed.
module vote_tally
  import evm_pkg::*;
#(
  parameter int WIDTH    = EVM_WIDTH,
  parameter int NUM_CAND = EVM_NUM_CAND
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic                                               ballot_en,
  input  logic [NUM_CAND-1:0]                                vote_btn,
  input  logic                                               close_poll,
  input  logic [((NUM_CAND > 1) ? $clog2(NUM_CAND) : 1)-1:0] sel_cand,
  output logic                                               armed,
  output logic                                               vote_ack,
  output logic                                               err_multi,
  output logic                                               full,
  output logic [WIDTH-1:0]                                   tally_num,
  output logic [WIDTH-1:0]                                   tally_den,
  output logic                                               res_valid
);

  localparam logic [WIDTH-1:0] W_MAX = {WIDTH{1'b1}};

  evm_state_t       r_state;
  logic             r_vote_ack;
  logic             r_err_multi;

  logic [WIDTH-1:0] w_count [NUM_CAND];
  logic [WIDTH-1:0] w_total;
  logic             w_any;
  logic             w_onehot;
  logic             w_multi;
  logic             w_cast;
  logic             w_full;
  logic             w_closed;
  logic [WIDTH-1:0] w_num;

  // A press is one-hot when exactly one bit is set: nonzero and clearing the
  // lowest set bit leaves nothing.
  assign w_any    = |vote_btn;
  assign w_onehot = w_any && ((vote_btn & (vote_btn - NUM_CAND'(1))) == '0);
  assign w_multi  = w_any && !w_onehot;

  // Close has priority over a vote in the same cycle, so it suppresses counting.
  assign w_cast   = (r_state == ST_ARMED) && w_onehot && !close_poll && !rst;
  assign w_full   = (w_total == W_MAX);
  assign w_closed = (r_state == ST_CLOSED);

  for (genvar k = 0; k < NUM_CAND; k++) begin : g_cand
    vote_counter #(.WIDTH(WIDTH)) u_cnt (
      .i_clk   (clk),
      .i_clr   (rst),
      .i_inc   (w_cast & vote_btn[k]),
      .o_count (w_count[k])
    );
  end

  vote_counter #(.WIDTH(WIDTH)) u_total (
    .i_clk   (clk),
    .i_clr   (rst),
    .i_inc   (w_cast),
    .o_count (w_total)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_vote_ack  <= 1'b0;
      r_err_multi <= 1'b0;
    end else begin
      r_vote_ack  <= 1'b0;
      r_err_multi <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (close_poll) begin
            r_state <= ST_CLOSED;
          end else if (ballot_en && !w_full) begin
            r_state <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (close_poll) begin
            r_state <= ST_CLOSED;
          end else if (w_onehot) begin
            r_state    <= ST_WAIT_REL;
            r_vote_ack <= 1'b1;
          end else if (w_multi) begin
            r_err_multi <= 1'b1;
          end
        end
        ST_WAIT_REL: begin
          if (close_poll) begin
            r_state <= ST_CLOSED;
          end else if (!w_any) begin
            r_state <= ST_IDLE;
          end
        end
        ST_CLOSED: begin
          r_state <= ST_CLOSED;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Out-of-range selections simply match no candidate and read as zero.
  always_comb begin
    w_num = '0;
    if (w_closed) begin
      for (int k = 0; k < NUM_CAND; k++) begin
        if (int'(sel_cand) == k) begin
          w_num = w_count[k];
        end
      end
    end
  end

  assign armed     = (r_state == ST_ARMED);
  assign vote_ack  = r_vote_ack;
  assign err_multi = r_err_multi;
  assign full      = w_full;
  assign tally_num = w_num;
  assign tally_den = (w_closed && (w_total != '0)) ? w_total : WIDTH'(1);
  assign res_valid = w_closed && (w_total != '0);

endmodule

// File: tb/tb_vote_tally.sv
// Bench for vote_tally: directed scenarios plus randomized traffic against a
// rule-level reference model of the ballot process.
module tb_vote_tally;
  import evm_pkg::*;

  localparam int W = 7;
  localparam int N = 4;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         ballot_en;
  logic [N-1:0] vote_btn;
  logic         close_poll;
  logic [1:0]   sel_cand;
  logic         armed;
  logic         vote_ack;
  logic         err_multi;
  logic         full;
  logic [W-1:0] tally_num;
  logic [W-1:0] tally_den;
  logic         res_valid;

  int checks = 0;
  int errors = 0;

  // Reference model: a ballot is either open (armed), awaiting button release,
  // or neither; the poll is open or closed; tallies are plain integers.
  int m_cnt [N];
  int m_total;
  bit m_closed, m_armed, m_wait, m_ack, m_err;

  vote_tally #(.WIDTH(W), .NUM_CAND(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .ballot_en  (ballot_en),
    .vote_btn   (vote_btn),
    .close_poll (close_poll),
    .sel_cand   (sel_cand),
    .armed      (armed),
    .vote_ack   (vote_ack),
    .err_multi  (err_multi),
    .full       (full),
    .tally_num  (tally_num),
    .tally_den  (tally_den),
    .res_valid  (res_valid)
  );

  always #5 clk = ~clk;

  // Apply the model's rules to the inputs presented at this edge, then advance.
  task automatic tick();
    int presses;
    presses = $countones(vote_btn);
    m_ack = 0;
    m_err = 0;
    if (rst) begin
      foreach (m_cnt[k]) m_cnt[k] = 0;
      m_total = 0; m_closed = 0; m_armed = 0; m_wait = 0;
    end else if (m_closed) begin
      // results are frozen
    end else if (close_poll) begin
      m_closed = 1; m_armed = 0; m_wait = 0;
    end else if (m_armed) begin
      if (presses == 1) begin
        for (int k = 0; k < N; k++) if (vote_btn[k]) m_cnt[k]++;
        m_total++;
        m_ack = 1; m_armed = 0; m_wait = 1;
      end else if (presses > 1) begin
        m_err = 1;
      end
    end else if (m_wait) begin
      if (presses == 0) m_wait = 0;
    end else if (ballot_en && m_total < MAXV) begin
      m_armed = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; ballot_en = 0; vote_btn = '0; close_poll = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic cast_vote(input int k);
    ballot_en = 1; tick(); ballot_en = 0;
    vote_btn = N'(1) << k; tick();
    vote_btn = '0; tick();
  endtask

  task automatic test_reset();
    sel_cand = 2'd0;
    idle_inputs();
    rst = 1; ballot_en = 1; vote_btn = 4'b0001; close_poll = 1;
    tick(); tick();
    idle_inputs();
    checks++;
    if ({armed, vote_ack, err_multi, full, res_valid} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 00000", {armed, vote_ack, err_multi, full, res_valid});
    end
    checks++;
    if (tally_num !== 0 || tally_den !== 1) begin
      errors++;
      $display("FAIL reset_operands got num=%0d den=%0d want num=0 den=1", tally_num, tally_den);
    end
    checks++;
    if (dut.w_total !== 0) begin
      errors++;
      $display("FAIL reset_total got %0d want 0", dut.w_total);
    end
  endtask

  task automatic test_single_vote();
    do_reset();
    ballot_en = 1; tick(); ballot_en = 0;
    checks++;
    if (armed !== 1'b1) begin
      errors++; $display("FAIL arm got armed=%b want 1", armed);
    end
    vote_btn = 4'b0010; tick();
    checks++;
    if (vote_ack !== 1'b1 || dut.w_count[1] !== 1 || dut.w_total !== 1 || armed !== 1'b0) begin
      errors++;
      $display("FAIL single_vote got ack=%b c1=%0d total=%0d armed=%b want 1 1 1 0",
               vote_ack, dut.w_count[1], dut.w_total, armed);
    end
    tick();
    checks++;
    if (vote_ack !== 1'b0) begin
      errors++; $display("FAIL ack_pulse got ack=%b want 0", vote_ack);
    end
    tick(); tick();
    checks++;
    if (dut.w_count[1] !== 1 || dut.w_total !== 1) begin
      errors++;
      $display("FAIL held_button got c1=%0d total=%0d want 1 1", dut.w_count[1], dut.w_total);
    end
    vote_btn = '0; tick();
  endtask

  task automatic test_multi_press();
    ballot_en = 1; tick(); ballot_en = 0;
    vote_btn = 4'b0110; tick();
    checks++;
    if (err_multi !== 1'b1 || armed !== 1'b1 || dut.w_total !== 1 || dut.w_count[2] !== 0) begin
      errors++;
      $display("FAIL multi_press got err=%b armed=%b total=%0d c2=%0d want 1 1 1 0",
               err_multi, armed, dut.w_total, dut.w_count[2]);
    end
    vote_btn = '0; ballot_en = 1; tick(); ballot_en = 0;
    checks++;
    if (err_multi !== 1'b0 || armed !== 1'b1 || vote_ack !== 1'b0) begin
      errors++;
      $display("FAIL multi_recover got err=%b armed=%b ack=%b want 0 1 0", err_multi, armed, vote_ack);
    end
    vote_btn = 4'b0100; tick();
    checks++;
    if (vote_ack !== 1'b1 || dut.w_count[2] !== 1 || dut.w_total !== 2) begin
      errors++;
      $display("FAIL multi_then_single got ack=%b c2=%0d total=%0d want 1 1 2",
               vote_ack, dut.w_count[2], dut.w_total);
    end
    vote_btn = '0; tick();
  endtask

  task automatic test_close_priority();
    do_reset();
    ballot_en = 1; tick(); ballot_en = 0;
    vote_btn = 4'b0001; close_poll = 1; tick();
    checks++;
    if (vote_ack !== 1'b0 || dut.w_count[0] !== 0 || armed !== 1'b0 || dut.r_state !== ST_CLOSED) begin
      errors++;
      $display("FAIL close_priority got ack=%b c0=%0d armed=%b state=%0d want 0 0 0 %0d",
               vote_ack, dut.w_count[0], armed, dut.r_state, ST_CLOSED);
    end
    idle_inputs(); ballot_en = 1; tick(); ballot_en = 0;
    checks++;
    if (armed !== 1'b0 || res_valid !== 1'b0 || tally_den !== 1) begin
      errors++;
      $display("FAIL closed_terminal got armed=%b valid=%b den=%0d want 0 0 1", armed, res_valid, tally_den);
    end
  endtask

  task automatic test_results();
    do_reset();
    sel_cand = 2'd0;
    cast_vote(0);
    checks++;
    if (tally_num !== 0 || res_valid !== 1'b0) begin
      errors++; $display("FAIL open_poll_hidden got num=%0d valid=%b want 0 0", tally_num, res_valid);
    end
    cast_vote(1); cast_vote(0); cast_vote(3); cast_vote(1); cast_vote(0);
    close_poll = 1; tick(); close_poll = 0;
    #1;
    checks++;
    if (tally_num !== 3 || tally_den !== 6 || res_valid !== 1'b1) begin
      errors++;
      $display("FAIL results_c0 got num=%0d den=%0d valid=%b want 3 6 1", tally_num, tally_den, res_valid);
    end
    sel_cand = 2'd2; #1;
    checks++;
    if (tally_num !== 0) begin
      errors++; $display("FAIL results_c2 got num=%0d want 0", tally_num);
    end
    sel_cand = 2'd3; #1;
    checks++;
    if (tally_num !== 1 || tally_den !== 6) begin
      errors++; $display("FAIL results_c3 got num=%0d den=%0d want 1 6", tally_num, tally_den);
    end
    sel_cand = 2'd1; #1;
    checks++;
    if (tally_num !== 2) begin
      errors++; $display("FAIL results_c1 got num=%0d want 2", tally_num);
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < MAXV; i++) begin
      cast_vote(int'($urandom_range(0, N - 1)));
      if (i == MAXV - 2) begin
        checks++;
        if (full !== 1'b0) begin
          errors++; $display("FAIL full_early got full=%b want 0 at total=%0d", full, MAXV - 1);
        end
      end
    end
    checks++;
    if (full !== 1'b1 || dut.w_total !== W'(MAXV)) begin
      errors++; $display("FAIL full_reach got full=%b total=%0d want 1 %0d", full, dut.w_total, MAXV);
    end
    ballot_en = 1; tick(); ballot_en = 0;
    vote_btn = 4'b1000; tick(); vote_btn = '0;
    checks++;
    if (armed !== 1'b0 || vote_ack !== 1'b0 || dut.w_total !== W'(MAXV)) begin
      errors++;
      $display("FAIL full_lockout got armed=%b ack=%b total=%0d want 0 0 %0d", armed, vote_ack, dut.w_total, MAXV);
    end
    close_poll = 1; tick(); close_poll = 0;
    sel_cand = 2'd3; #1;
    checks++;
    if (tally_den !== W'(MAXV) || tally_num !== W'(m_cnt[3])) begin
      errors++;
      $display("FAIL full_results got num=%0d den=%0d want %0d %0d", tally_num, tally_den, m_cnt[3], MAXV);
    end
  endtask

  task automatic test_zero_close();
    do_reset();
    close_poll = 1; tick(); close_poll = 0;
    sel_cand = 2'd0; #1;
    checks++;
    if (tally_den !== 1 || res_valid !== 1'b0 || tally_num !== 0) begin
      errors++;
      $display("FAIL zero_close got den=%0d valid=%b num=%0d want 1 0 0", tally_den, res_valid, tally_num);
    end
    rst = 1; ballot_en = 1; close_poll = 1; tick();
    idle_inputs();
    checks++;
    if (armed !== 1'b0 || dut.r_state !== ST_IDLE || dut.w_total !== 0) begin
      errors++;
      $display("FAIL reset_from_closed got armed=%b state=%0d total=%0d want 0 %0d 0",
               armed, dut.r_state, dut.w_total, ST_IDLE);
    end
    ballot_en = 1; tick(); ballot_en = 0;
    checks++;
    if (armed !== 1'b1) begin
      errors++; $display("FAIL rearm_after_reset got armed=%b want 1", armed);
    end
  endtask

  task automatic test_random();
    logic [4:0]   exp_flags;
    logic [W-1:0] exp_num;
    logic [W-1:0] exp_den;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst        = ($urandom_range(0, 499) == 0);
      close_poll = ($urandom_range(0, 149) == 0);
      ballot_en  = ($urandom_range(0, 2) == 0);
      sel_cand   = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0, 1:    vote_btn = '0;
        2, 3, 4: vote_btn = N'(1) << $urandom_range(0, N - 1);
        default: vote_btn = N'($urandom);
      endcase
      // Reopen the poll periodically so votes keep flowing after a close.
      if (m_closed && $urandom_range(0, 19) == 0) rst = 1;
      tick();
      exp_flags = {m_armed, m_ack, m_err, (m_total == MAXV), (m_closed && m_total > 0)};
      exp_num   = m_closed ? W'(m_cnt[sel_cand]) : W'(0);
      exp_den   = (m_closed && m_total > 0) ? W'(m_total) : W'(1);
      checks++;
      if ({armed, vote_ack, err_multi, full, res_valid, tally_num, tally_den} !==
          {exp_flags, exp_num, exp_den}) begin
        errors++;
        $display("FAIL random_cycle%0d got flags=%b num=%0d den=%0d want flags=%b num=%0d den=%0d",
                 cyc, {armed, vote_ack, err_multi, full, res_valid}, tally_num, tally_den,
                 exp_flags, exp_num, exp_den);
      end
      checks++;
      if (dut.w_total !== W'(m_total)) begin
        errors++;
        $display("FAIL random_total%0d got %0d want %0d", cyc, dut.w_total, m_total);
      end
    end
    idle_inputs();
  endtask

  initial begin
    foreach (m_cnt[k]) m_cnt[k] = 0;
    m_total = 0; m_closed = 0; m_armed = 0; m_wait = 0; m_ack = 0; m_err = 0;
    idle_inputs();
    sel_cand = 2'd0;
    #2;
    test_reset();
    test_single_vote();
    test_multi_press();
    test_close_priority();
    test_results();
    test_full();
    test_zero_close();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vote_tally.md
VOTE_TALLY -- requirements
Module: vote_tally

Interface
REQ-001 The block SHALL have parameter WIDTH, default 7: bit width of every tally and of both divider operand outputs.
REQ-002 The block SHALL have parameter NUM_CAND, default 4: number of candidates.
REQ-003 The block SHALL have input clk, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have input rst, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have input ballot_en, 1 bit: officer pulse that arms exactly one vote.
REQ-006 The block SHALL have input vote_btn, NUM_CAND bits: candidate buttons, already debounced and synchronous to clk.
REQ-007 The block SHALL have input close_poll, 1 bit: ends voting permanently until rst.
REQ-008 The block SHALL have input sel_cand, clog2(NUM_CAND) bits: candidate whose tally is presented in results mode.
REQ-009 The block SHALL have output armed, 1 bit: high while a vote may be cast.
REQ-010 The block SHALL have output vote_ack, 1 bit: one-cycle pulse when a vote has been counted.
REQ-011 The block SHALL have output err_multi, 1 bit: one-cycle pulse when a multi-button press is rejected.
REQ-012 The block SHALL have output full, 1 bit: high when total equals 2^WIDTH-1.
REQ-013 The block SHALL have output tally_num, WIDTH bits: dividend for the downstream divider (selected candidate's count).
REQ-014 The block SHALL have output tally_den, WIDTH bits: divisor for the downstream divider (total votes, never 0).
REQ-015 The block SHALL have output res_valid, 1 bit: high when tally_num/tally_den are meaningful results.

Function
REQ-016 The block SHALL implement the FSM states IDLE, ARMED, WAIT_REL and CLOSED.
REQ-017 IDLE: ballot_en=1 with full=0 SHALL move the FSM to ARMED; ballot_en with full=1 SHALL be ignored.
REQ-018 ARMED, vote_btn one-hot: the selected count and the total SHALL each increment by 1 on that edge; vote_ack SHALL be 1 in the next cycle; the FSM SHALL go to WAIT_REL.
REQ-019 ARMED, more than one vote_btn bit set: counts SHALL be unchanged; err_multi SHALL pulse next cycle; the FSM SHALL stay ARMED.
REQ-020 ARMED, vote_btn=0: the FSM SHALL hold; ballot_en SHALL be ignored (no stacking of ballots).
REQ-021 WAIT_REL: the FSM SHALL return to IDLE on the first cycle with vote_btn=0; presses in WAIT_REL SHALL never count.
REQ-022 close_poll=1 in IDLE, ARMED or WAIT_REL SHALL force CLOSED next cycle; a vote presented in the same cycle SHALL be discarded (close has priority); an armed ballot SHALL be lost.
REQ-023 CLOSED: the state SHALL be terminal; all counts frozen; ballot_en, vote_btn and close_poll ignored.
REQ-024 armed SHALL be 1 exactly when state is ARMED.
REQ-025 full SHALL be combinational from total; once full, no further ARMED entry; an ARMED state entered before full cannot exist because the ballot that fills total completes first.
REQ-026 Individual counts SHALL never exceed total, so no per-candidate overflow check is required; total SHALL never wrap.
REQ-027 tally_num SHALL equal count[sel_cand] combinationally in CLOSED and 0 otherwise; sel_cand >= NUM_CAND SHALL give 0.
REQ-028 tally_den SHALL equal total in CLOSED when total>0, and 1 otherwise (the divisor is never 0).
REQ-029 res_valid SHALL equal (state==CLOSED) and (total>0).
REQ-030 Vote latency SHALL be one cycle: the press is sampled at edge N, and count, total and vote_ack are visible after edge N.

Reset
REQ-031 On rst=1 at a clock edge, the state SHALL become IDLE and all counts and total SHALL become 0, regardless of state, including mid-vote and CLOSED.
REQ-032 Reset output values SHALL be: armed=0, vote_ack=0, err_multi=0, full=0, tally_num=0, tally_den=1, res_valid=0.
REQ-033 rst SHALL take priority over every other input in the same cycle.

Structure
REQ-034 Shared package evm_pkg SHALL hold WIDTH and NUM_CAND defaults, the FSM state enum, and the constant TALLY_MAX = 2^WIDTH-1; the downstream divider SHALL use the same WIDTH.
REQ-035 Sub-module vote_counter SHALL be instantiated NUM_CAND+1 times (one per candidate plus total); it is a WIDTH-bit counter with sync clear, increment enable and registered count.
REQ-036 The one-hot check and the FSM SHALL reside in vote_tally.

Verification
REQ-037 The bench SHALL cover: rst; ballot_en; vote_btn=4'b0010 -> after one edge, count[1]=1, total=1, vote_ack one cycle high; vote_btn held 3 cycles -> no further counts.
REQ-038 The bench SHALL cover: ARMED, vote_btn=4'b0110 -> err_multi pulse, counts unchanged, armed stays 1; then 4'b0100 -> count[2]=1.
REQ-039 The bench SHALL cover: ARMED plus vote_btn=4'b0001 plus close_poll in the same cycle -> CLOSED, count[0] unchanged, no vote_ack.
REQ-040 The bench SHALL cover: votes 3,2,0,1 for candidates 0..3, then close_poll, sel_cand=0 -> tally_num=3, tally_den=6, res_valid=1; sel_cand=2 -> tally_num=0.
REQ-041 The bench SHALL cover: 127 votes -> full=1, next ballot_en ignored (armed stays 0), total stays 127.
REQ-042 The bench SHALL cover: close with zero votes -> tally_den=1, res_valid=0; then rst in CLOSED -> IDLE, all counts 0.
